// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the APB-side master of the I2C controller:
// FSM encoding and the register map of the attached I2C core.
package i2c_apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic [7:0] ADDR_PRESCALER  = 8'h00;
   localparam logic [7:0] ADDR_CMD        = 8'h01;
   localparam logic [7:0] ADDR_TRANSMIT   = 8'h02;
   localparam logic [7:0] ADDR_RECEIVE    = 8'h03;
   localparam logic [7:0] ADDR_ADDRESS_RW = 8'h04;
   localparam logic [7:0] ADDR_STATUS     = 8'h05;

endpackage

// File: rtl/i2c_apb_master.sv
// Single-outstanding APB master: turns one host command into one APB transfer,
// with a wait-state timeout that reports an error instead of hanging.
//
// state  | meaning
// IDLE   | bus idle, ready for a host command once the response pulse is gone
// SETUP  | psel high, address/data presented, one cycle only
// ACCESS | penable high, waiting for pready or the wait-state timeout
module i2c_apb_master
   import i2c_apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       pclk_i,
   input  logic       preset_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_write_i,
   input  logic [7:0] cmd_addr_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_rdata_o,
   output logic       rsp_error_o,
   output logic       psel_o,
   output logic       penable_o,
   output logic       pwrite_o,
   output logic [7:0] paddr_o,
   output logic [7:0] pwdata_o,
   input  logic [7:0] prdata_i,
   input  logic       pready_i
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   apb_state_e state_q, state_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_error_q, rsp_error_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;
   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [7:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (cmd_valid_i && cmd_ready_q) begin
               state_d    = ST_SETUP;
               psel_d     = 1'b1;
               pwrite_d   = cmd_write_i;
               paddr_d    = cmd_addr_i;
               pwdata_d   = cmd_wdata_i;
               wait_cnt_d = 8'd0;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            // pready wins over the timeout when both land on the same cycle
            if (pready_i) begin
               state_d     = ST_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? 8'h00 : prdata_i;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d     = ST_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = 8'h00;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase

      // The response cycle is itself idle on APB, so the next transfer is
      // always separated by at least one psel-low cycle.
      cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 8'h00;
         pwdata_q    <= 8'h00;
         wait_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;

endmodule
